// File: rtl/ascon_job_arbiter.sv
// ascon_job_arbiter: round-robin arbiter that runs one requester's job at a time through a shared ASCON cipher core.
module ascon_job_arbiter #(
    parameter int BLK_SIZE   = 64,
    parameter int NONCE_SIZE = 128,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*NONCE_SIZE-1:0] req_nonce,
    input  logic [2*CNT_W-1:0]      req_nblk,
    input  logic                    pt_valid,
    output logic                    pt_ready,
    input  logic [BLK_SIZE-1:0]     pt_data,
    output logic                    ct_valid,
    input  logic                    ct_ready,
    output logic [BLK_SIZE-1:0]     ct_data,
    output logic                    ct_last,
    output logic                    tag_valid,
    output logic [127:0]            tag,
    output logic                    job_id,
    output logic                    c_start,
    output logic [NONCE_SIZE-1:0]   c_nonce,
    output logic                    c_pt_valid,
    input  logic                    c_pt_ready,
    output logic [BLK_SIZE-1:0]     c_pt,
    input  logic [BLK_SIZE-1:0]     c_ct,
    input  logic                    c_ct_valid,
    output logic                    c_ct_ready,
    output logic                    c_ct_last,
    input  logic [127:0]            c_tag,
    input  logic                    c_busy
);
    typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, TAG} state_t;
    state_t state, state_nx;
    logic ptr, gnt, any_req, in_done, at_last;
    logic [CNT_W-1:0] in_cnt, out_cnt, nblk_q;
    logic [NONCE_SIZE-1:0] nonce_q;
    logic [127:0] tag_q;
    assign any_req = |req_valid;
    assign gnt = (req_valid == 2'b11) ? ptr : req_valid[1];
    assign at_last = out_cnt == nblk_q;
    assign c_nonce = nonce_q;
    assign c_pt = pt_data;
    assign ct_data = c_ct;
    assign c_ct_last = ct_last;
    assign tag = tag_q;
    always_comb begin
        state_nx = state;
        req_ready = 2'b00;
        c_start = 1'b0;
        pt_ready = 1'b0;
        c_pt_valid = 1'b0;
        ct_valid = 1'b0;
        c_ct_ready = 1'b0;
        ct_last = 1'b0;
        tag_valid = 1'b0;
        case (state)
            IDLE: begin
                // gated by rst so no ready escapes while reset is held
                req_ready = {gnt, ~gnt} & {2{any_req & rst}};
                state_nx = any_req ? START : IDLE;
            end
            START: begin
                c_start = 1'b1;
                state_nx = STREAM;
            end
            STREAM: begin
                pt_ready = c_pt_ready & ~in_done;
                c_pt_valid = pt_valid & ~in_done;
                ct_valid = c_ct_valid;
                c_ct_ready = ct_ready;
                ct_last = at_last;
                state_nx = (c_ct_valid & ct_ready & at_last) ? DRAIN : STREAM;
            end
            DRAIN: state_nx = c_busy ? DRAIN : TAG;
            TAG: begin
                tag_valid = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // in_done stands in for in_cnt = nblk+1 so a full 2^CNT_W-block job never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr <= 1'b0;
            job_id <= 1'b0;
            nonce_q <= '0;
            nblk_q <= '0;
            in_cnt <= '0;
            out_cnt <= '0;
            in_done <= 1'b0;
            tag_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                job_id <= gnt;
                nonce_q <= gnt ? req_nonce[2*NONCE_SIZE-1:NONCE_SIZE] : req_nonce[NONCE_SIZE-1:0];
                nblk_q <= gnt ? req_nblk[2*CNT_W-1:CNT_W] : req_nblk[CNT_W-1:0];
                in_cnt <= '0;
                out_cnt <= '0;
                in_done <= 1'b0;
            end
            if (pt_valid & pt_ready) begin
                if (in_cnt == nblk_q) in_done <= 1'b1;
                else in_cnt <= in_cnt + 1'b1;
            end
            if (c_ct_valid & c_ct_ready & ~at_last) out_cnt <= out_cnt + 1'b1;
            if (state == DRAIN && !c_busy) tag_q <= c_tag;
            if (state == TAG) ptr <= ~job_id;
        end
    end
endmodule
